// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM for a shared-memory datapath.
// Decodes R-type, I-type ALU, LW, SW, BEQ, BNE, J and JAL. A memory read
// (instruction fetch or load) waits MEM_WAIT extra cycles. Unknown opcodes
// trap in an absorbing ILLEGAL state. Every control output is registered:
// each edge loads the decode of the state and wait count being entered,
// so the outputs always equal the decode of the current state and count.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 1,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op_code,
  input  logic [5:0] Funct,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       BranchNE,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       branch_ne;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  ctl_t            ctl_q;

  // Control word for a given state and wait count; anything not set stays 0.
  function automatic ctl_t decode(input state_t s, input logic [CW-1:0] w,
                                  input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 3'b001;
        if (w == WAIT_LAST) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
        end
      end
      S_DECODE: c.alu_src_b = 3'b011;
      S_EXEC_R: begin
        c.alu_op = 2'b10;
        if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA) begin
          c.alu_src_a = 2'b10;
          c.alu_src_b = 3'b100;
        end else begin
          c.alu_src_a = 2'b01;
        end
      end
      S_R_WB: begin
        c.reg_dst    = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 2'b01;
        c.alu_op    = 2'b11;
        c.alu_src_b = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? 3'b101 : 3'b010;
      end
      S_I_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 3'b010;
      end
      S_MEM_RD: c.iord = 1'b1;
      S_MEM_WB: begin
        c.mem_to_reg = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 2'b01;
        c.alu_op        = 2'b01;
        c.pc_source     = 2'b01;
        c.pc_write_cond = 1'b1;
        c.branch_ne     = (op == OP_BNE);
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_source  = 2'b10;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so it is the link value for $31.
        c.pc_source  = 2'b10;
        c.pc_write   = 1'b1;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state and wait count; the counter only advances while a read is
  // still waiting and is zero after every transition.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (wcnt_q == WAIT_LAST) state_d = S_DECODE;
        else                     wcnt_d  = wcnt_q + CW'(1);
      end
      S_DECODE: begin
        case (Op_code)
          OP_RTYPE:                                           state_d = S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                                       state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                                     state_d = S_BRANCH;
          OP_J:                                               state_d = S_JUMP;
          OP_JAL:                                             state_d = S_JAL;
          default:                                            state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (Op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (wcnt_q == WAIT_LAST) state_d = S_MEM_WB;
        else                     wcnt_d  = wcnt_q + CW'(1);
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR,
      S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
      S_ILLEGAL:               state_d = S_ILLEGAL;
      default:                 state_d = S_FETCH;
    endcase
  end

  // State, counter and registered control word; reset forces FETCH at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      ctl_q   <= decode(S_FETCH, '0, 6'd0, 6'd0);
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ctl_q   <= decode(state_d, wcnt_d, Op_code, Funct);
    end
  end

  assign MemWrite    = ctl_q.mem_write;
  assign IRWrite     = ctl_q.ir_write;
  assign RegWrite    = ctl_q.reg_write;
  assign PCWrite     = ctl_q.pc_write;
  assign PCWriteCond = ctl_q.pc_write_cond;
  assign IorD        = ctl_q.iord;
  assign BranchNE    = ctl_q.branch_ne;
  assign RegDst      = ctl_q.reg_dst;
  assign MemtoReg    = ctl_q.mem_to_reg;
  assign ALUSrcA     = ctl_q.alu_src_a;
  assign ALUSrcB     = ctl_q.alu_src_b;
  assign ALUOp       = ctl_q.alu_op;
  assign PCSource    = ctl_q.pc_source;
  assign instr_done  = ctl_q.instr_done;
  assign illegal     = ctl_q.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. Three instances (MEM_WAIT 0, 1, 2)
// run independent instruction streams. Each issued instruction pushes its
// expected per-cycle control words, built from the instruction timing rules,
// into that instance's queue; one monitor pops and compares every cycle.
module tb_multicycle_ctrl;

  localparam int NINST   = 3;
  localparam int ILL_CYC = 20;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       branch_ne;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_v [NINST];
  logic [5:0] op_v  [NINST];
  logic [5:0] fn_v  [NINST];
  ctl_t       act   [NINST];
  ctl_t       exp_q [NINST][$];
  int         vectors     = 0;
  int         miscompares = 0;
  bit         monitor_on  = 1'b1;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
    logic MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond, IorD, BranchNE;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUOp, PCSource;
    logic [2:0] ALUSrcB;
    logic instr_done, illegal;

    multicycle_ctrl #(.MEM_WAIT(gi), .CW(4)) u_dut (
      .clk(clk), .rst(rst_v[gi]), .Op_code(op_v[gi]), .Funct(fn_v[gi]),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .BranchNE(BranchNE), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .illegal(illegal)
    );

    assign act[gi] = '{MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond, IorD,
                       BranchNE, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                       PCSource, instr_done, illegal};
  end

  // Instruction class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 branch, 5 J, 6 JAL, 7 illegal.
  function automatic int cls(input logic [5:0] op);
    case (op)
      6'h00:                                     return 0;
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: return 1;
      6'h23:                                     return 2;
      6'h2B:                                     return 3;
      6'h04, 6'h05:                              return 4;
      6'h02:                                     return 5;
      6'h03:                                     return 6;
      default:                                   return 7;
    endcase
  endfunction

  // Cycle count of an instruction; for a trap, fetch + decode + a watched span.
  function automatic int instr_len(input logic [5:0] op, input int w);
    case (cls(op))
      0, 1, 3: return w + 4;
      2:       return 2 * w + 5;
      4, 5, 6: return w + 3;
      default: return w + 2 + ILL_CYC;
    endcase
  endfunction

  function automatic ctl_t fetch_vec(input bit last);
    ctl_t v;
    v = '0;
    v.alu_src_b = 3'd1;
    v.ir_write  = last;
    v.pc_write  = last;
    return v;
  endfunction

  // Expected control word in cycle i (0-based) of an instruction.
  function automatic ctl_t instr_vec(input logic [5:0] op, input logic [5:0] fn,
                                     input int w, input int i);
    ctl_t v;
    int   j;
    bit   shift, logical;
    v = '0;
    if (i <= w) return fetch_vec(i == w);
    if (i == w + 1) begin
      v.alu_src_b = 3'd3;
      return v;
    end
    j       = i - w - 2;
    shift   = (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03);
    logical = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    case (cls(op))
      0: if (j == 0) begin
           v.alu_op    = 2'd2;
           v.alu_src_a = shift ? 2'd2 : 2'd1;
           v.alu_src_b = shift ? 3'd4 : 3'd0;
         end else begin
           v.reg_dst = 2'd1; v.reg_write = 1'b1; v.instr_done = 1'b1;
         end
      1: if (j == 0) begin
           v.alu_src_a = 2'd1; v.alu_op = 2'd3;
           v.alu_src_b = logical ? 3'd5 : 3'd2;
         end else begin
           v.reg_write = 1'b1; v.instr_done = 1'b1;
         end
      2: if (j == 0) begin
           v.alu_src_a = 2'd1; v.alu_src_b = 3'd2;
         end else if (j <= w + 1) begin
           v.iord = 1'b1;
         end else begin
           v.mem_to_reg = 2'd1; v.reg_write = 1'b1; v.instr_done = 1'b1;
         end
      3: if (j == 0) begin
           v.alu_src_a = 2'd1; v.alu_src_b = 3'd2;
         end else begin
           v.iord = 1'b1; v.mem_write = 1'b1; v.instr_done = 1'b1;
         end
      4: begin
           v.alu_src_a = 2'd1; v.alu_op = 2'd1; v.pc_source = 2'd1;
           v.pc_write_cond = 1'b1; v.branch_ne = (op == 6'h05); v.instr_done = 1'b1;
         end
      5: begin
           v.pc_source = 2'd2; v.pc_write = 1'b1; v.instr_done = 1'b1;
         end
      6: begin
           v.pc_source = 2'd2; v.pc_write = 1'b1; v.reg_dst = 2'd2;
           v.mem_to_reg = 2'd2; v.reg_write = 1'b1; v.instr_done = 1'b1;
         end
      default: v.illegal = 1'b1;
    endcase
    return v;
  endfunction

  // Monitor: during reset the outputs must be the idle FETCH word; otherwise
  // each cycle that has a pending expectation is popped and compared.
  always @(negedge clk) begin
    if (monitor_on) begin
      for (int k = 0; k < NINST; k++) begin
        ctl_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        if (rst_v[k]) begin
          e    = fetch_vec(k == 0);
          have = 1'b1;
        end else if (exp_q[k].size() > 0) begin
          e    = exp_q[k].pop_front();
          have = 1'b1;
        end
        if (have) begin
          vectors++;
          if (act[k] !== e) begin
            miscompares++;
            $display("FAIL ctl inst%0d (MEM_WAIT=%0d) t=%0t: got %h required %h",
                     k, k, $time, act[k], e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst_v[k] = 1'b1;
    exp_q[k].delete();
    repeat (2) tick();
    rst_v[k] = 1'b0;
  endtask

  // Issue one instruction; if cut is shorter than the instruction (or it
  // traps), reset is raised after cut cycles.
  task automatic issue(input int k, input logic [5:0] op, input logic [5:0] fn,
                       input int cut);
    int len;
    len = instr_len(op, k);
    for (int i = 0; i < len; i++) exp_q[k].push_back(instr_vec(op, fn, k, i));
    op_v[k] = op;
    fn_v[k] = fn;
    $display("inst%0d op=%02h fn=%02h len=%0d cut=%0d", k, op, fn, len, cut);
    repeat (cut) tick();
    if (cut < len || cls(op) == 7) do_reset(k);
  endtask

  task automatic run_inst(input int k);
    logic [5:0] dir_op [17] = '{6'h00, 6'h23, 6'h2B, 6'h05, 6'h04, 6'h0D, 6'h00, 6'h03,
                                6'h02, 6'h08, 6'h0C, 6'h0E, 6'h0A, 6'h09, 6'h00, 6'h00,
                                6'h00};
    logic [5:0] dir_fn [17] = '{6'h20, 6'h11, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03,
                                6'h2A};
    logic [5:0] legal [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                               6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    logic [5:0] op, fn;
    int         len, cut;
    rst_v[k] = 1'b1;
    op_v[k]  = 6'd0;
    fn_v[k]  = 6'd0;
    repeat (2) tick();
    rst_v[k] = 1'b0;
    for (int i = 0; i < 17; i++) issue(k, dir_op[i], dir_fn[i], instr_len(dir_op[i], k));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else                           op = legal[$urandom_range(0, 12)];
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 3));
      else                           fn = 6'($urandom_range(0, 63));
      len = instr_len(op, k);
      if (cls(op) == 7)                   cut = $urandom_range(k + 2, len);
      else if ($urandom_range(0, 7) == 0) cut = $urandom_range(1, len - 1);
      else                                cut = len;
      issue(k, op, fn, cut);
    end
    // Trap held for the full watched span, then a clean instruction after reset.
    issue(k, 6'h3F, 6'h00, instr_len(6'h3F, k));
    issue(k, 6'h00, 6'h20, instr_len(6'h00, k));
    // Reset landing inside the fetch wait (or first cycle when there is no wait).
    issue(k, 6'h23, 6'h00, (k > 0) ? k : 1);
    issue(k, 6'h23, 6'h00, instr_len(6'h23, k));
  endtask

  initial begin
    for (int k = 0; k < NINST; k++) begin
      rst_v[k] = 1'b1;
      op_v[k]  = 6'd0;
      fn_v[k]  = 6'd0;
    end
    fork
      run_inst(0);
      run_inst(1);
      run_inst(2);
    join
    tick();
    monitor_on = 1'b0;
    for (int k = 0; k < NINST; k++) begin
      if (exp_q[k].size() != 0) begin
        miscompares++;
        $display("FAIL drain inst%0d: got %0d pending required 0", k, exp_q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion required finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
